// File: rtl/rs_alu.sv
// Reservation station for the integer ALU: buffers dispatched ops, snoops ALU/LSB
// result broadcasts, issues one ready op per cycle. Optional macro RS_AGE_SELECT_EN.

module rs_alu_entry #(
  parameter int ROB_WIDTH = 4
`ifdef RS_AGE_SELECT_EN
  , parameter int RS_WIDTH = 3
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 clear,
  input  logic                 wr,
  input  logic                 take,
  input  logic [3:0]           d_opcode,
  input  logic [31:0]          d_vj,
  input  logic                 d_qj_busy,
  input  logic [ROB_WIDTH-1:0] d_qj,
  input  logic [31:0]          d_vk,
  input  logic                 d_qk_busy,
  input  logic [ROB_WIDTH-1:0] d_qk,
  input  logic [ROB_WIDTH-1:0] d_tag,
  input  logic                 alu_done,
  input  logic [31:0]          alu_value,
  input  logic [ROB_WIDTH-1:0] alu_tag,
  input  logic                 lsb_done,
  input  logic [31:0]          lsb_value,
  input  logic [ROB_WIDTH-1:0] lsb_tag,
  output logic                 busy,
  output logic                 ready,
  output logic [3:0]           opcode,
  output logic [31:0]          vj,
  output logic [31:0]          vk,
  output logic [ROB_WIDTH-1:0] tag
`ifdef RS_AGE_SELECT_EN
  , output logic [RS_WIDTH-1:0] age
`endif
);
  logic                 qj_busy, qk_busy;
  logic [ROB_WIDTH-1:0] qj, qk;

  assign ready = busy & ~qj_busy & ~qk_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      opcode  <= '0;
      vj      <= '0;
      vk      <= '0;
      qj_busy <= 1'b0;
      qk_busy <= 1'b0;
      qj      <= '0;
      qk      <= '0;
      tag     <= '0;
`ifdef RS_AGE_SELECT_EN
      age     <= '0;
`endif
    end else if (rdy) begin
      if (clear) begin
        busy <= 1'b0;
      end else if (wr) begin
        busy    <= 1'b1;
        opcode  <= d_opcode;
        vj      <= d_vj;
        vk      <= d_vk;
        qj_busy <= d_qj_busy;
        qk_busy <= d_qk_busy;
        qj      <= d_qj;
        qk      <= d_qk;
        tag     <= d_tag;
`ifdef RS_AGE_SELECT_EN
        age     <= '0;
`endif
      end else if (busy) begin
        if (take) begin
          busy <= 1'b0;
        end else begin
          // ALU wins if both broadcasts name the same tag
          if (qj_busy) begin
            if (alu_done && qj == alu_tag) begin
              vj <= alu_value; qj_busy <= 1'b0;
            end else if (lsb_done && qj == lsb_tag) begin
              vj <= lsb_value; qj_busy <= 1'b0;
            end
          end
          if (qk_busy) begin
            if (alu_done && qk == alu_tag) begin
              vk <= alu_value; qk_busy <= 1'b0;
            end else if (lsb_done && qk == lsb_tag) begin
              vk <= lsb_value; qk_busy <= 1'b0;
            end
          end
`ifdef RS_AGE_SELECT_EN
          if (age != '1) age <= age + 1'b1;
`endif
        end
      end
    end
  end
endmodule

module rs_alu #(
  parameter int RS_WIDTH  = 3,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_signal,
  input  logic                 dispatch_signal,
  input  logic [3:0]           dispatch_opcode,
  input  logic [31:0]          dispatch_vj,
  input  logic                 dispatch_qj_busy,
  input  logic [ROB_WIDTH-1:0] dispatch_qj,
  input  logic [31:0]          dispatch_vk,
  input  logic                 dispatch_qk_busy,
  input  logic [ROB_WIDTH-1:0] dispatch_qk,
  input  logic [ROB_WIDTH-1:0] dispatch_tag,
  output logic                 rs_full,
  input  logic                 alu_done,
  input  logic [31:0]          alu_value,
  input  logic [ROB_WIDTH-1:0] alu_tag,
  input  logic                 lsb_done,
  input  logic [31:0]          lsb_value,
  input  logic [ROB_WIDTH-1:0] lsb_tag,
  output logic                 cal_signal,
  output logic [3:0]           opcode,
  output logic [31:0]          lhs,
  output logic [31:0]          rhs,
  output logic [ROB_WIDTH-1:0] tag
);
  localparam int N = 1 << RS_WIDTH;

  typedef struct packed {
    logic [3:0]           opcode;
    logic [31:0]          lhs;
    logic [31:0]          rhs;
    logic [ROB_WIDTH-1:0] tag;
  } issue_t;

  logic [N-1:0]                busy, ready, wr, take;
  logic [N-1:0][3:0]           e_op;
  logic [N-1:0][31:0]          e_vj, e_vk;
  logic [N-1:0][ROB_WIDTH-1:0] e_tag;
`ifdef RS_AGE_SELECT_EN
  logic [N-1:0][RS_WIDTH-1:0]  e_age;
  logic [RS_WIDTH-1:0]         best_age;
`endif

  logic [RS_WIDTH-1:0] free_idx, iss_idx;
  logic                free_any, iss_any, dispatch_fire, issue_fire;
  logic                d_qjb, d_qkb;
  logic [31:0]         d_vj, d_vk;
  issue_t              iss_q;
  logic                cal_q;

  assign rs_full = &busy;

  // Operand bypass for a broadcast landing in the same cycle as dispatch
  always_comb begin
    d_qjb = dispatch_qj_busy;
    d_vj  = dispatch_vj;
    if (dispatch_qj_busy) begin
      if (alu_done && alu_tag == dispatch_qj) begin
        d_qjb = 1'b0; d_vj = alu_value;
      end else if (lsb_done && lsb_tag == dispatch_qj) begin
        d_qjb = 1'b0; d_vj = lsb_value;
      end
    end
    d_qkb = dispatch_qk_busy;
    d_vk  = dispatch_vk;
    if (dispatch_qk_busy) begin
      if (alu_done && alu_tag == dispatch_qk) begin
        d_qkb = 1'b0; d_vk = alu_value;
      end else if (lsb_done && lsb_tag == dispatch_qk) begin
        d_qkb = 1'b0; d_vk = lsb_value;
      end
    end
  end

  always_comb begin
    free_idx = '0;
    free_any = 1'b0;
    for (int i = N-1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx = RS_WIDTH'(i);
        free_any = 1'b1;
      end
    end
  end

  always_comb begin
    iss_idx = '0;
    iss_any = 1'b0;
`ifdef RS_AGE_SELECT_EN
    best_age = '0;
    // Strict compare keeps the lowest index on equal (saturated) ages
    for (int i = 0; i < N; i++) begin
      if (ready[i] && (!iss_any || e_age[i] > best_age)) begin
        iss_idx  = RS_WIDTH'(i);
        iss_any  = 1'b1;
        best_age = e_age[i];
      end
    end
`else
    for (int i = N-1; i >= 0; i--) begin
      if (ready[i]) begin
        iss_idx = RS_WIDTH'(i);
        iss_any = 1'b1;
      end
    end
`endif
  end

  assign dispatch_fire = rdy_in & ~clear_signal & dispatch_signal & free_any;
  assign issue_fire    = rdy_in & ~clear_signal & iss_any;

  always_comb begin
    wr   = '0;
    take = '0;
    for (int i = 0; i < N; i++) begin
      wr[i]   = dispatch_fire && (free_idx == RS_WIDTH'(i));
      take[i] = issue_fire && (iss_idx == RS_WIDTH'(i));
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_ent
    rs_alu_entry #(
      .ROB_WIDTH(ROB_WIDTH)
`ifdef RS_AGE_SELECT_EN
      , .RS_WIDTH(RS_WIDTH)
`endif
    ) u_ent (
      .clk(clk_in), .rst_n(rst_in), .rdy(rdy_in), .clear(clear_signal),
      .wr(wr[g]), .take(take[g]),
      .d_opcode(dispatch_opcode), .d_vj(d_vj), .d_qj_busy(d_qjb), .d_qj(dispatch_qj),
      .d_vk(d_vk), .d_qk_busy(d_qkb), .d_qk(dispatch_qk), .d_tag(dispatch_tag),
      .alu_done(alu_done), .alu_value(alu_value), .alu_tag(alu_tag),
      .lsb_done(lsb_done), .lsb_value(lsb_value), .lsb_tag(lsb_tag),
      .busy(busy[g]), .ready(ready[g]), .opcode(e_op[g]),
      .vj(e_vj[g]), .vk(e_vk[g]), .tag(e_tag[g])
`ifdef RS_AGE_SELECT_EN
      , .age(e_age[g])
`endif
    );
  end

  // Payload only reloads on issue; it holds across idle cycles and pauses
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cal_q <= 1'b0;
      iss_q <= '0;
    end else if (rdy_in) begin
      cal_q <= issue_fire;
      if (issue_fire) begin
        iss_q.opcode <= e_op[iss_idx];
        iss_q.lhs    <= e_vj[iss_idx];
        iss_q.rhs    <= e_vk[iss_idx];
        iss_q.tag    <= e_tag[iss_idx];
      end
    end
  end

  assign cal_signal = cal_q;
  assign opcode     = iss_q.opcode;
  assign lhs        = iss_q.lhs;
  assign rhs        = iss_q.rhs;
  assign tag        = iss_q.tag;
endmodule

// File: tb/tb_rs_alu.sv
// Bench for rs_alu: a queue-free slot model tracks the station every cycle, and
// directed scenarios add literal expectations.
module tb_rs_alu;
  localparam int RS_WIDTH = 3, ROB_WIDTH = 4, N = 8;

  logic clk = 0, rst_n = 0, rdy = 1, clr = 0, dsig = 0;
  logic [3:0] dop = 0, dqj = 0, dqk = 0, dtag = 0, at = 0, lt = 0;
  logic [31:0] dvj = 0, dvk = 0, av = 0, lv = 0;
  logic dqjb = 0, dqkb = 0, ad = 0, ld = 0;
  logic rs_full, cal;
  logic [3:0] op, tg;
  logic [31:0] lhs, rhs;

  int checks = 0, errors = 0;

  rs_alu #(.RS_WIDTH(RS_WIDTH), .ROB_WIDTH(ROB_WIDTH)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .clear_signal(clr),
    .dispatch_signal(dsig), .dispatch_opcode(dop), .dispatch_vj(dvj),
    .dispatch_qj_busy(dqjb), .dispatch_qj(dqj), .dispatch_vk(dvk),
    .dispatch_qk_busy(dqkb), .dispatch_qk(dqk), .dispatch_tag(dtag),
    .rs_full(rs_full), .alu_done(ad), .alu_value(av), .alu_tag(at),
    .lsb_done(ld), .lsb_value(lv), .lsb_tag(lt), .cal_signal(cal),
    .opcode(op), .lhs(lhs), .rhs(rhs), .tag(tg));

  always #5 clk = ~clk;

  typedef struct {
    bit busy; logic [3:0] op; logic [31:0] vj, vk;
    bit qjb, qkb; logic [3:0] qj, qk, tg; int seq;
  } ent_t;

  ent_t m[N];
  bit m_cal = 0;
  logic [3:0] m_op = 0, m_tag = 0;
  logic [31:0] m_lhs = 0, m_rhs = 0;
  int seqc = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // One operand as captured: a matching broadcast supplies the value now
  task automatic snoop(inout bit b, input logic [3:0] q, inout logic [31:0] v);
    if (b && ad && q == at) begin b = 0; v = av; end
    else if (b && ld && q == lt) begin b = 0; v = lv; end
  endtask

  task automatic step();
    ent_t nx[N];
    bit full;
    int pick;
    if (clr) begin
      for (int i = 0; i < N; i++) m[i].busy = 0;
      m_cal = 0;
      return;
    end
    full = 1;
    for (int i = 0; i < N; i++) if (!m[i].busy) full = 0;
    pick = -1;
    for (int i = 0; i < N; i++)
      if (m[i].busy && !m[i].qjb && !m[i].qkb) begin
`ifdef RS_AGE_SELECT_EN
        if (pick < 0 || m[i].seq < m[pick].seq) pick = i;
`else
        if (pick < 0) pick = i;
`endif
      end
    nx = m;
    if (pick >= 0) begin
      m_cal = 1; m_op = m[pick].op; m_lhs = m[pick].vj; m_rhs = m[pick].vk;
      m_tag = m[pick].tg; nx[pick].busy = 0;
    end else m_cal = 0;
    for (int i = 0; i < N; i++)
      if (nx[i].busy) begin
        snoop(nx[i].qjb, nx[i].qj, nx[i].vj);
        snoop(nx[i].qkb, nx[i].qk, nx[i].vk);
      end
    if (dsig && !full) begin
      for (int i = 0; i < N; i++)
        if (!m[i].busy) begin
          nx[i].busy = 1; nx[i].op = dop; nx[i].vj = dvj; nx[i].vk = dvk;
          nx[i].qjb = dqjb; nx[i].qkb = dqkb; nx[i].qj = dqj; nx[i].qk = dqk;
          nx[i].tg = dtag; nx[i].seq = seqc++;
          snoop(nx[i].qjb, nx[i].qj, nx[i].vj);
          snoop(nx[i].qkb, nx[i].qk, nx[i].vk);
          break;
        end
    end
    m = nx;
  endtask

  initial begin
    for (int i = 0; i < N; i++) m[i].busy = 0;
    forever begin
      @(posedge clk);
      if (rst_n && rdy) step();
    end
  end

  // Every cycle out of reset: DUT outputs against the model
  initial forever begin
    int cnt;
    @(negedge clk);
    if (rst_n) begin
      cnt = 0;
      for (int i = 0; i < N; i++) if (m[i].busy) cnt++;
      chk("m_full", {31'b0, rs_full}, {31'b0, cnt == N});
      chk("m_cal", {31'b0, cal}, {31'b0, m_cal});
      chk("m_opcode", {28'b0, op}, {28'b0, m_op});
      chk("m_lhs", lhs, m_lhs);
      chk("m_rhs", rhs, m_rhs);
      chk("m_tag", {28'b0, tg}, {28'b0, m_tag});
    end
  end

  task automatic tick();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic idle();
    dsig = 0; ad = 0; ld = 0; clr = 0;
  endtask

  task automatic dsp(input logic [3:0] o, input logic [31:0] vj, input bit qjb,
                     input logic [3:0] qj, input logic [31:0] vk, input bit qkb,
                     input logic [3:0] qk, input logic [3:0] t);
    dsig = 1; dop = o; dvj = vj; dqjb = qjb; dqj = qj;
    dvk = vk; dqkb = qkb; dqk = qk; dtag = t;
  endtask

  task automatic fill_pending9();
    for (int i = 0; i < N; i++) begin
      dsp(4'd4, 32'd0, 1, 4'd9, 32'd100 + i, 0, 4'd0, 4'(i));
      tick();
    end
    idle();
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    chk("rst_cal", {31'b0, cal}, 0);
    chk("rst_opcode", {28'b0, op}, 0);
    chk("rst_lhs", lhs, 0);
    chk("rst_rhs", rhs, 0);
    chk("rst_tag", {28'b0, tg}, 0);
    chk("rst_full", {31'b0, rs_full}, 0);
    rst_n = 1;

    // ADD 5,7 tag 3: one edge to dispatch, next edge issues
    dsp(4'd4, 32'd5, 0, 4'd0, 32'd7, 0, 4'd0, 4'd3);
    tick(); idle();
    chk("t1_latency", {31'b0, cal}, 0);
    tick();
    chk("t1_cal", {31'b0, cal}, 1);
    chk("t1_opcode", {28'b0, op}, 4);
    chk("t1_lhs", lhs, 5);
    chk("t1_rhs", rhs, 7);
    chk("t1_tag", {28'b0, tg}, 3);
    tick();
    chk("t1_drop", {31'b0, cal}, 0);

    // lhs pending on tag 2, woken by ALU
    dsp(4'd5, 32'd0, 1, 4'd2, 32'd1, 0, 4'd0, 4'd4);
    tick(); idle();
    ad = 1; at = 4'd2; av = 32'd10;
    tick(); idle();
    chk("t2_wait", {31'b0, cal}, 0);
    tick();
    chk("t2_cal", {31'b0, cal}, 1);
    chk("t2_lhs", lhs, 10);
    chk("t2_rhs", rhs, 1);

    // rhs captured from same-cycle LSB broadcast
    dsp(4'd6, 32'd3, 0, 4'd0, 32'd0, 1, 4'd6, 4'd5);
    ld = 1; lt = 4'd6; lv = 32'hFF;
    tick(); idle();
    tick();
    chk("t3_cal", {31'b0, cal}, 1);
    chk("t3_lhs", lhs, 3);
    chk("t3_rhs", rhs, 32'hFF);
    tick();

    // Fill, overflow dispatch ignored, then wake all eight
    fill_pending9();
    chk("t4_full", {31'b0, rs_full}, 1);
    dsp(4'd7, 32'd1, 0, 4'd0, 32'd1, 0, 4'd0, 4'd15);
    tick(); idle();
    chk("t4_full_hold", {31'b0, rs_full}, 1);
    chk("t4_no_issue", {31'b0, cal}, 0);
    ad = 1; at = 4'd9; av = 32'd50;
    tick(); idle();
    for (int i = 0; i < N; i++) begin
      tick();
      chk("t4_cal", {31'b0, cal}, 1);
      chk("t4_tag", {28'b0, tg}, 32'(i));
      chk("t4_lhs", lhs, 50);
      chk("t4_rhs", rhs, 32'd100 + i);
      if (i == 0) chk("t4_full_drop", {31'b0, rs_full}, 0);
    end
    tick();
    chk("t4_end", {31'b0, cal}, 0);

    // Flush a full station; no stale issue afterwards
    fill_pending9();
    chk("t5_full", {31'b0, rs_full}, 1);
    clr = 1;
    tick(); idle();
    chk("t5_full_clr", {31'b0, rs_full}, 0);
    chk("t5_cal_clr", {31'b0, cal}, 0);
    ad = 1; at = 4'd9; av = 32'd77;
    tick(); idle();
    tick();
    chk("t5_stale", {31'b0, cal}, 0);

    // Pause: outputs frozen, clear and dispatch ignored, then resume
    dsp(4'd4, 32'd11, 0, 4'd0, 32'd1, 0, 4'd0, 4'd6);
    tick();
    dsp(4'd4, 32'd22, 0, 4'd0, 32'd2, 0, 4'd0, 4'd7);
    tick(); idle();
    rdy = 0; clr = 1;
    dsp(4'd9, 32'd99, 0, 4'd0, 32'd99, 0, 4'd0, 4'd12);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_hold_cal", {31'b0, cal}, 1);
      chk("t6_hold_tag", {28'b0, tg}, 6);
      chk("t6_hold_lhs", lhs, 11);
    end
    rdy = 1; idle();
    tick();
    chk("t6_resume_cal", {31'b0, cal}, 1);
    chk("t6_resume_tag", {28'b0, tg}, 7);
    chk("t6_resume_lhs", lhs, 22);
    tick();
    chk("t6_end", {31'b0, cal}, 0);

    // Both operands pending, woken by ALU and LSB on one edge
    dsp(4'd8, 32'd0, 1, 4'd1, 32'd0, 1, 4'd2, 4'd10);
    tick(); idle();
    ad = 1; at = 4'd1; av = 32'hAA;
    ld = 1; lt = 4'd2; lv = 32'hBB;
    tick(); idle();
    tick();
    chk("t7_cal", {31'b0, cal}, 1);
    chk("t7_lhs", lhs, 32'hAA);
    chk("t7_rhs", rhs, 32'hBB);
    chk("t7_tag", {28'b0, tg}, 10);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
